// File: rtl/io_write_arbiter_if.sv
// Write-port bundle between I/O event sources, arbiter and register handshaker.
// master: arbiter side; slave: requesters + handshaker side.
interface io_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            Req_Valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data;
  logic [NUM_REQ-1:0]            Req_Ack;
  logic [DATA_WIDTH-1:0]         IO_WrData;
  logic                          IO_WrEn;
  logic                          IO_Busy;
  logic [IDW-1:0]                Grant_Id;
  logic                          Active;

  modport master (
    input  Req_Valid, Req_Data, IO_Busy,
    output Req_Ack, IO_WrData, IO_WrEn,
    output Grant_Id, Active
  );

  modport slave (
    output Req_Valid, Req_Data, IO_Busy,
    input  Req_Ack, IO_WrData, IO_WrEn,
    input  Grant_Id, Active
  );
endinterface

// File: rtl/io_write_arbiter.sv
// Round-robin arbiter sharing one read-clear register write port among NUM_REQ
// sources. Ports: Clock, Reset (sync, active-low), bus (io_write_arbiter_if.master).
module io_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic               Clock,
  input logic               Reset,
  io_write_arbiter_if.master bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT
  } state_t;

  state_t state, state_d;

  logic [IDW-1:0]        ptr, ptr_nxt, sel, gid;
  logic [NUM_REQ-1:0]    sel_oh, ack;
  logic [DATA_WIDTH-1:0] sel_data, wdata;
  logic                  found, load, wren;

  // Pass 0 scans ptr..NUM_REQ-1, pass 1 wraps to 0..ptr-1.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_oh   = '0;
    sel_data = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && bus.Req_Valid[i] &&
            ((p == 0) == (i >= int'(ptr)))) begin
          found     = 1'b1;
          sel       = IDW'(i);
          sel_oh[i] = 1'b1;
          sel_data  =
            bus.Req_Data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign ptr_nxt = (gid == IDW'(NUM_REQ - 1)) ?
                   '0 : gid + IDW'(1);

  always_comb begin
    state_d = state;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found && !bus.IO_Busy) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:  state_d = SETTLE;
      // Busy may not have risen yet; skip it here.
      SETTLE: state_d = WAIT;
      WAIT: begin
        if (!bus.IO_Busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
      ptr   <= '0;
      wren  <= 1'b0;
      ack   <= '0;
      wdata <= '0;
      gid   <= '0;
    end else begin
      state <= state_d;
      wren  <= load;
      ack   <= load ? sel_oh : '0;
      if (load) begin
        wdata <= sel_data;
        gid   <= sel;
      end
      if (state == ISSUE) ptr <= ptr_nxt;
    end
  end

  assign bus.Req_Ack   = ack;
  assign bus.IO_WrEn   = wren;
  assign bus.IO_WrData = wdata;
  assign bus.Grant_Id  = gid;
  assign bus.Active    = (state != IDLE);
endmodule
